stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Control FSM for the stopwatch datapath: turns debounced button pulses into a start/pause/lap/clear sequence for the 8-bit event counter.
- Generates the counter's enable tick from a clock prescaler.
- Strobes the counter's tri-state read and latches the result into a display register.
- Sits between the button debouncers and the counter/display in the stopwatch top level.

Parameters:
- TICK_DIV, 100, clk cycles per count tick (>=2).
- CW, 8, counter/data width.

Ports:
- clk  in  1  system clock.
- reset_b  in  1  async active-low reset.
- btn_start  in  1  one-cycle pulse; start/pause toggle.
- btn_lap  in  1  one-cycle pulse; lap freeze/release.
- btn_clear  in  1  one-cycle pulse; clear to zero.
- cnt_data  in  CW  counter data bus (valid only while cnt_read=1).
- cnt_enable  out  1  counter enable, one-cycle tick pulse.
- cnt_read  out  1  counter bus output enable.
- cnt_clr_b  out  1  counter soft clear, active-low, one-cycle pulse.
- disp_value  out  CW  displayed time.
- state  out  3  current FSM state.
- ovf  out  1  sticky overflow flag.

Behaviour:
- Reset values: state=IDLE, cnt_enable=0, cnt_read=0, cnt_clr_b=1, disp_value=0, ovf=0, prescaler=0. All outputs are registered.
- State encoding: IDLE=0, RUN=1, PAUSE=2, LAP=3, CLEAR=4.
- Button priority when pulses coincide: clear > start > lap. Only the winner acts.
- Transitions:
  - IDLE: start -> RUN; lap ignored.
  - RUN: start -> PAUSE; lap -> LAP.
  - LAP: lap -> RUN; start -> PAUSE, with display unfrozen on entry.
  - PAUSE: start -> RUN; lap ignored.
  - Any state: clear -> CLEAR.
  - CLEAR: unconditional -> IDLE after 1 cycle.
- CLEAR actions: cnt_clr_b=0 for exactly that cycle; prescaler, disp_value and ovf cleared.
- Prescaler:
  - Counts 0..TICK_DIV-1 in RUN and LAP, wrapping.
  - cnt_enable=1 for the single cycle after prescaler==TICK_DIV-1.
  - Holds its value in PAUSE, so resume keeps the partial period.
  - Held at 0 in IDLE and CLEAR.
  - No tick is issued in the cycle a transition to PAUSE/CLEAR takes effect.
- Read sequencing:
  - cnt_read=1 in exactly the cycle after each cnt_enable pulse, which is when the counter already holds the new value.
  - At the end of that cycle cnt_data is sampled into the shadow register.
  - The same sample goes to disp_value unless state==LAP.
  - Latency: cnt_enable high -> disp_value updated 2 edges later.
  - cnt_read is 0 at all other times.
  - cnt_data is never sampled while cnt_read=0.
- LAP:
  - disp_value frozen at the value held on LAP entry; counting continues.
  - On release (lap -> RUN, or start -> PAUSE), disp_value <= shadow in the transition cycle.
- Wrap-around: counter wraps 255->0 naturally; the controller does not block ticks.
- Reset asserted mid-operation: all state is lost and the block returns to IDLE; the counter is reset by the same reset_b.

Optional Feature:
- Macro: STOPWATCH_OVF_EN.
- Defined:
  - ovf is set on the cycle cnt_enable is issued while shadow == 2^CW-1.
  - Sticky until CLEAR or reset.
- Undefined: ovf is tied to 0 and no comparator logic is present. The port always exists.

Decomposition:
- stopwatch_pkg holds:
  - the state enum (IDLE/RUN/PAUSE/LAP/CLEAR) and its 3-bit width;
  - the CW default;
  - the button priority constants.
- One sub-module: sw_tick_prescaler, containing the divide counter with run/hold/clear inputs and a tick output, parameterised by TICK_DIV.
- FSM, read sequencing and display/shadow registers stay in stopwatch_ctrl.

Test Plan (TICK_DIV=4, with a behavioural model of the counter attached):
- Reset, then idle 10 cycles -> state=0, cnt_enable=0, cnt_read=0, cnt_clr_b=1, disp_value=0, ovf=0 throughout.
- start pulse, run 40 cycles -> 10 cnt_enable pulses exactly 4 cycles apart, each followed by cnt_read on the next cycle; disp_value=10 two edges after the 10th pulse.
- Pause/resume timing:
  - start at 2 cycles after a tick -> PAUSE; 20 cycles with no cnt_enable and disp_value held.
  - start again -> first tick comes 2 cycles after resume, because the prescaler fraction is preserved.
- LAP freeze and release:
  - lap at disp_value=5 -> state=3; disp_value stays 5 while counter reaches 9.
  - lap again -> disp_value=9 that cycle, and 10 after the next tick.
- btn_clear and btn_start pulsed in the same cycle during RUN -> state CLEAR (4) for 1 cycle, cnt_clr_b=0 for 1 cycle, disp_value=0, then IDLE; no PAUSE entered.
- 256 ticks from zero -> counter wraps to 0 and disp_value=0. With STOPWATCH_OVF_EN, ovf=1 from the wrapping tick until clear. Without the macro, ovf remains 0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
//   Shared types and constants for the stopwatch controller slice.
//   - sw_state_t    : controller FSM state (3-bit, value visible on the state port)
//   - btn_sel_t     : winning button after arbitration (higher code wins)
//   - btn_arbitrate : resolves coincident button pulses, clear > start > lap
//   - CW_DEFAULT    : default counter/data width
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    localparam int STATE_W    = 3;
    localparam int CW_DEFAULT = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_LAP   = 3'd3,
        ST_CLEAR = 3'd4
    } sw_state_t;

    // Encoded so that a larger value means a higher-priority button.
    typedef enum logic [1:0] {
        BTN_NONE  = 2'd0,
        BTN_LAP   = 2'd1,
        BTN_START = 2'd2,
        BTN_CLEAR = 2'd3
    } btn_sel_t;

    // Only the highest-priority pulse of a coincident set is acted upon.
    function automatic btn_sel_t btn_arbitrate(input logic clr,
                                               input logic start,
                                               input logic lap);
        btn_sel_t sel;
        sel = BTN_NONE;
        if (clr) begin
            sel = BTN_CLEAR;
        end else if (start) begin
            sel = BTN_START;
        end else if (lap) begin
            sel = BTN_LAP;
        end
        return sel;
    endfunction

endpackage

// File: rtl/sw_tick_prescaler.sv
// -----------------------------------------------------------------------------
// sw_tick_prescaler
//   Divide-by-TICK_DIV counter producing the count tick for the stopwatch.
//   Ports:
//     clk, reset_b : clock, asynchronous active-low reset
//     run          : advance the divider this cycle (otherwise it holds)
//     clr          : force the divider back to 0 (wins over run)
//     tick         : combinational, high in the advancing cycle in which the
//                    divider sits at TICK_DIV-1 (the caller registers it)
//   Parameter TICK_DIV (>= 2): clk cycles per tick.
// -----------------------------------------------------------------------------
module sw_tick_prescaler #(
    parameter int TICK_DIV = 100
) (
    input  logic clk,
    input  logic reset_b,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int            PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] count_q;
    logic [PW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (run) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    assign tick = run && !clr && (count_q == LAST);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   Control FSM for the stopwatch datapath. Turns debounced button pulses into
//   start / pause / lap / clear behaviour, generates the counter enable tick,
//   strobes the counter's tri-state read and latches the value for display.
//   Ports:
//     clk, reset_b   : clock, asynchronous active-low reset (shared with counter)
//     btn_start      : start/pause toggle pulse
//     btn_lap        : lap freeze/release pulse
//     btn_clear      : clear-to-zero pulse (highest priority)
//     cnt_data       : counter bus, only meaningful while cnt_read=1
//     cnt_enable     : one-cycle count tick to the counter
//     cnt_read       : counter bus output enable, the cycle after each tick
//     cnt_clr_b      : one-cycle active-low soft clear to the counter
//     disp_value     : displayed time
//     state          : current FSM state (sw_state_t encoding)
//     ovf            : sticky overflow flag
//   Build option: define STOPWATCH_OVF_EN to enable the overflow detector;
//   without it ovf is constant 0.
// -----------------------------------------------------------------------------
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 100,
    parameter int CW       = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_b,
    input  logic          btn_start,
    input  logic          btn_lap,
    input  logic          btn_clear,
    input  logic [CW-1:0] cnt_data,
    output logic          cnt_enable,
    output logic          cnt_read,
    output logic          cnt_clr_b,
    output logic [CW-1:0] disp_value,
    output logic [2:0]    state,
    output logic          ovf
);

    sw_state_t     state_q,      state_d;
    logic          cnt_enable_q, cnt_enable_d;
    logic          cnt_read_q,   cnt_read_d;
    logic          cnt_clr_b_q,  cnt_clr_b_d;
    logic [CW-1:0] shadow_q,     shadow_d;
    logic [CW-1:0] disp_q,       disp_d;
`ifdef STOPWATCH_OVF_EN
    logic          ovf_q,        ovf_d;
`endif

    btn_sel_t btn;
    logic     running_now;
    logic     running_next;
    logic     pre_run;
    logic     pre_clr;
    logic     pre_tick;
    logic     lap_release;

    assign btn = btn_arbitrate(btn_clear, btn_start, btn_lap);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q      <= ST_IDLE;
            cnt_enable_q <= 1'b0;
            cnt_read_q   <= 1'b0;
            cnt_clr_b_q  <= 1'b1;
            shadow_q     <= '0;
            disp_q       <= '0;
`ifdef STOPWATCH_OVF_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_enable_q <= cnt_enable_d;
            cnt_read_q   <= cnt_read_d;
            cnt_clr_b_q  <= cnt_clr_b_d;
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
`ifdef STOPWATCH_OVF_EN
            ovf_q        <= ovf_d;
`endif
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (btn == BTN_START) state_d = ST_RUN;
            ST_RUN: begin
                if (btn == BTN_START)      state_d = ST_PAUSE;
                else if (btn == BTN_LAP)   state_d = ST_LAP;
            end
            ST_LAP: begin
                if (btn == BTN_START)      state_d = ST_PAUSE;
                else if (btn == BTN_LAP)   state_d = ST_RUN;
            end
            ST_PAUSE: if (btn == BTN_START) state_d = ST_RUN;
            ST_CLEAR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (btn == BTN_CLEAR) begin
            state_d = ST_CLEAR;
        end
    end

    // The divider only advances while we stay in a counting state, so a
    // pause taken mid-period keeps the fraction and never emits a tick.
    assign running_now  = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign running_next = (state_d == ST_RUN) || (state_d == ST_LAP);
    assign pre_run      = running_now && running_next;
    assign pre_clr      = (state_q == ST_IDLE) || (state_q == ST_CLEAR) ||
                          (state_d == ST_CLEAR);
    assign lap_release  = (state_q == ST_LAP) &&
                          ((state_d == ST_RUN) || (state_d == ST_PAUSE));

    sw_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_b (reset_b),
        .run     (pre_run),
        .clr     (pre_clr),
        .tick    (pre_tick)
    );

    // ---------------- output / datapath logic ----------------
    always_comb begin
        cnt_enable_d = pre_tick;
        // Counter has taken the tick at the end of the enable cycle, so its
        // bus holds the new value one cycle later.
        cnt_read_d   = cnt_enable_q;
        cnt_clr_b_d  = (state_d != ST_CLEAR);
        shadow_d     = shadow_q;
        disp_d       = disp_q;

        if (cnt_read_q) begin
            shadow_d = cnt_data;
            if (state_q != ST_LAP) begin
                disp_d = cnt_data;
            end
        end
        // Leaving LAP shows the latest value, including one sampled this cycle.
        if (lap_release) begin
            disp_d = shadow_d;
        end
        if (state_d == ST_CLEAR) begin
            shadow_d = '0;
            disp_d   = '0;
        end

`ifdef STOPWATCH_OVF_EN
        ovf_d = ovf_q;
        // Shadow at all-ones means this tick rolls the counter over.
        if (cnt_enable_d && (shadow_q == {CW{1'b1}})) begin
            ovf_d = 1'b1;
        end
        if (state_d == ST_CLEAR) begin
            ovf_d = 1'b0;
        end
`endif
    end

    assign cnt_enable = cnt_enable_q;
    assign cnt_read   = cnt_read_q;
    assign cnt_clr_b  = cnt_clr_b_q;
    assign disp_value = disp_q;
    assign state      = state_q;
`ifdef STOPWATCH_OVF_EN
    assign ovf        = ovf_q;
`else
    assign ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//   Directed bench for stopwatch_ctrl with TICK_DIV=4 and a behavioural 8-bit
//   counter attached. Inputs change and outputs are observed on the falling
//   clock edge.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int TD = 4;
    localparam int CW = 8;
`ifdef STOPWATCH_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_b = 1'b0;
    logic          btn_start = 1'b0;
    logic          btn_lap = 1'b0;
    logic          btn_clear = 1'b0;
    logic [CW-1:0] cnt_data;
    logic          cnt_enable;
    logic          cnt_read;
    logic          cnt_clr_b;
    logic [CW-1:0] disp_value;
    logic [2:0]    state;
    logic          ovf;
    logic [CW-1:0] model_cnt;

    int n_cmp = 0;
    int n_err = 0;

    stopwatch_ctrl #(
        .TICK_DIV (TD),
        .CW       (CW)
    ) dut (
        .clk        (clk),
        .reset_b    (reset_b),
        .btn_start  (btn_start),
        .btn_lap    (btn_lap),
        .btn_clear  (btn_clear),
        .cnt_data   (cnt_data),
        .cnt_enable (cnt_enable),
        .cnt_read   (cnt_read),
        .cnt_clr_b  (cnt_clr_b),
        .disp_value (disp_value),
        .state      (state),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    // Behavioural event counter; bus carries junk unless read is enabled.
    always @(posedge clk or negedge reset_b) begin
        if (!reset_b)        model_cnt <= '0;
        else if (!cnt_clr_b) model_cnt <= '0;
        else if (cnt_enable) model_cnt <= model_cnt + 8'd1;
    end
    assign cnt_data = cnt_read ? model_cnt : 8'hA5;

    task automatic pulse(input logic c, input logic s, input logic l, input string what);
        $display("txn %-12s t=%0t state=%0d disp=%0d", what, $time, state, disp_value);
        btn_clear = c;
        btn_start = s;
        btn_lap   = l;
        @(negedge clk);
        btn_clear = 1'b0;
        btn_start = 1'b0;
        btn_lap   = 1'b0;
    endtask

    task automatic test_reset();
        reset_b = 1'b0;
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state cyc%0d: got %0d want 0", i, state); end
            n_cmp++; if (cnt_enable !== 1'b0) begin n_err++; $display("FAIL reset_enable cyc%0d: got %b want 0", i, cnt_enable); end
            n_cmp++; if (cnt_read !== 1'b0) begin n_err++; $display("FAIL reset_read cyc%0d: got %b want 0", i, cnt_read); end
            n_cmp++; if (cnt_clr_b !== 1'b1) begin n_err++; $display("FAIL reset_clr_b cyc%0d: got %b want 1", i, cnt_clr_b); end
            n_cmp++; if (disp_value !== 8'd0) begin n_err++; $display("FAIL reset_disp cyc%0d: got %0d want 0", i, disp_value); end
            n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf cyc%0d: got %b want 0", i, ovf); end
        end
        $display("txn reset_done   t=%0t", $time);
    endtask

    // Entered RUN at cycle 1; ticks at cycles 5,9,...,41, reads one cycle later.
    task automatic test_run();
        logic exp_en;
        logic exp_rd;
        int   n_ticks;
        n_ticks = 0;
        pulse(1'b0, 1'b1, 1'b0, "start");
        n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL run_enter_state: got %0d want 1", state); end
        for (int k = 2; k <= 43; k++) begin
            @(negedge clk);
            exp_en = (k >= 5) && (k <= 41) && (((k - 5) % TD) == 0);
            exp_rd = (k >= 6) && (k <= 42) && (((k - 6) % TD) == 0);
            if (cnt_enable) n_ticks++;
            n_cmp++; if (cnt_enable !== exp_en) begin n_err++; $display("FAIL run_enable cyc%0d: got %b want %b", k, cnt_enable, exp_en); end
            n_cmp++; if (cnt_read !== exp_rd) begin n_err++; $display("FAIL run_read cyc%0d: got %b want %b", k, cnt_read, exp_rd); end
            if (k == 42) begin
                n_cmp++; if (disp_value !== 8'd9) begin n_err++; $display("FAIL run_disp_pre: got %0d want 9", disp_value); end
            end
            if (k == 43) begin
                n_cmp++; if (disp_value !== 8'd10) begin n_err++; $display("FAIL run_disp_10: got %0d want 10", disp_value); end
            end
        end
        n_cmp++; if (n_ticks != 10) begin n_err++; $display("FAIL run_tick_count: got %0d want 10", n_ticks); end
    endtask

    task automatic test_pause_resume();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (cnt_enable) found = 1'b1;
        end
        n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL pause_sync_tick: got %b want 1", found); end
        repeat (2) @(negedge clk);
        pulse(1'b0, 1'b1, 1'b0, "start(pause)");
        n_cmp++; if (state !== 3'd2) begin n_err++; $display("FAIL pause_state: got %0d want 2", state); end
        n_cmp++; if (disp_value !== 8'd11) begin n_err++; $display("FAIL pause_disp: got %0d want 11", disp_value); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++; if (cnt_enable !== 1'b0) begin n_err++; $display("FAIL pause_enable cyc%0d: got %b want 0", i, cnt_enable); end
            n_cmp++; if (cnt_read !== 1'b0) begin n_err++; $display("FAIL pause_read cyc%0d: got %b want 0", i, cnt_read); end
            n_cmp++; if (disp_value !== 8'd11) begin n_err++; $display("FAIL pause_hold cyc%0d: got %0d want 11", i, disp_value); end
        end
        pulse(1'b0, 1'b1, 1'b0, "start(resume)");
        n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL resume_state: got %0d want 1", state); end
        n_cmp++; if (cnt_enable !== 1'b0) begin n_err++; $display("FAIL resume_en_c1: got %b want 0", cnt_enable); end
        @(negedge clk);
        n_cmp++; if (cnt_enable !== 1'b0) begin n_err++; $display("FAIL resume_en_c2: got %b want 0", cnt_enable); end
        @(negedge clk);
        n_cmp++; if (cnt_enable !== 1'b1) begin n_err++; $display("FAIL resume_en_c3: got %b want 1", cnt_enable); end
        @(negedge clk);
        n_cmp++; if (cnt_read !== 1'b1) begin n_err++; $display("FAIL resume_read: got %b want 1", cnt_read); end
        @(negedge clk);
        n_cmp++; if (disp_value !== 8'd12) begin n_err++; $display("FAIL resume_disp: got %0d want 12", disp_value); end
    endtask

    task automatic test_clear_priority();
        pulse(1'b1, 1'b1, 1'b0, "clear+start");
        n_cmp++; if (state !== 3'd4) begin n_err++; $display("FAIL clr_state: got %0d want 4", state); end
        n_cmp++; if (cnt_clr_b !== 1'b0) begin n_err++; $display("FAIL clr_pulse: got %b want 0", cnt_clr_b); end
        n_cmp++; if (disp_value !== 8'd0) begin n_err++; $display("FAIL clr_disp: got %0d want 0", disp_value); end
        n_cmp++; if (cnt_enable !== 1'b0) begin n_err++; $display("FAIL clr_enable: got %b want 0", cnt_enable); end
        @(negedge clk);
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL clr_to_idle: got %0d want 0", state); end
        n_cmp++; if (cnt_clr_b !== 1'b1) begin n_err++; $display("FAIL clr_release: got %b want 1", cnt_clr_b); end
        n_cmp++; if (model_cnt !== 8'd0) begin n_err++; $display("FAIL clr_counter: got %0d want 0", model_cnt); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL clr_idle_hold cyc%0d: got %0d want 0", i, state); end
            n_cmp++; if (disp_value !== 8'd0) begin n_err++; $display("FAIL clr_disp_hold cyc%0d: got %0d want 0", i, disp_value); end
        end
    endtask

    task automatic test_lap();
        logic found;
        found = 1'b0;
        pulse(1'b0, 1'b1, 1'b0, "start");
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (disp_value == 8'd5) found = 1'b1;
        end
        n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL lap_sync_disp5: got %b want 1", found); end
        pulse(1'b0, 1'b0, 1'b1, "lap(freeze)");
        n_cmp++; if (state !== 3'd3) begin n_err++; $display("FAIL lap_state: got %0d want 3", state); end
        n_cmp++; if (disp_value !== 8'd5) begin n_err++; $display("FAIL lap_disp_entry: got %0d want 5", disp_value); end
        for (int j = 2; j <= 16; j++) begin
            @(negedge clk);
            n_cmp++; if (disp_value !== 8'd5) begin n_err++; $display("FAIL lap_frozen cyc%0d: got %0d want 5", j, disp_value); end
            n_cmp++; if (state !== 3'd3) begin n_err++; $display("FAIL lap_state_hold cyc%0d: got %0d want 3", j, state); end
        end
        n_cmp++; if (model_cnt !== 8'd9) begin n_err++; $display("FAIL lap_counter: got %0d want 9", model_cnt); end
        pulse(1'b0, 1'b0, 1'b1, "lap(release)");
        n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL lap_release_state: got %0d want 1", state); end
        n_cmp++; if (disp_value !== 8'd9) begin n_err++; $display("FAIL lap_release_disp: got %0d want 9", disp_value); end
        repeat (2) @(negedge clk);
        n_cmp++; if (disp_value !== 8'd9) begin n_err++; $display("FAIL lap_post_hold: got %0d want 9", disp_value); end
        @(negedge clk);
        n_cmp++; if (disp_value !== 8'd10) begin n_err++; $display("FAIL lap_post_tick: got %0d want 10", disp_value); end
    endtask

    task automatic test_wrap();
        int   n;
        logic exp_ovf;
        pulse(1'b1, 1'b0, 1'b0, "clear");
        @(negedge clk);
        pulse(1'b0, 1'b1, 1'b0, "start(wrap)");
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL wrap_ovf_start: got %b want 0", ovf); end
        n = 0;
        for (int i = 0; i < 1100 && n < 256; i++) begin
            @(negedge clk);
            if (cnt_enable) begin
                n++;
                exp_ovf = (n == 256) ? OVF_ON : 1'b0;
                n_cmp++; if (ovf !== exp_ovf) begin n_err++; $display("FAIL wrap_ovf tick%0d: got %b want %b", n, ovf, exp_ovf); end
            end
        end
        n_cmp++; if (n != 256) begin n_err++; $display("FAIL wrap_tick_budget: got %0d want 256", n); end
        repeat (2) @(negedge clk);
        n_cmp++; if (disp_value !== 8'd0) begin n_err++; $display("FAIL wrap_disp: got %0d want 0", disp_value); end
        n_cmp++; if (model_cnt !== 8'd0) begin n_err++; $display("FAIL wrap_counter: got %0d want 0", model_cnt); end
        repeat (5) @(negedge clk);
        n_cmp++; if (ovf !== OVF_ON) begin n_err++; $display("FAIL wrap_ovf_sticky: got %b want %b", ovf, OVF_ON); end
        pulse(1'b1, 1'b0, 1'b0, "clear");
        n_cmp++; if (state !== 3'd4) begin n_err++; $display("FAIL wrap_clr_state: got %0d want 4", state); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL wrap_ovf_cleared: got %b want 0", ovf); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        pulse(1'b0, 1'b1, 1'b0, "start");
        repeat (10) @(negedge clk);
        n_cmp++; if (disp_value !== 8'd2) begin n_err++; $display("FAIL areset_pre_disp: got %0d want 2", disp_value); end
        #2 reset_b = 1'b0;
        $display("txn reset_assert t=%0t", $time);
        #1;
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL areset_state: got %0d want 0", state); end
        n_cmp++; if (disp_value !== 8'd0) begin n_err++; $display("FAIL areset_disp: got %0d want 0", disp_value); end
        n_cmp++; if (cnt_clr_b !== 1'b1) begin n_err++; $display("FAIL areset_clr_b: got %b want 1", cnt_clr_b); end
        n_cmp++; if (cnt_read !== 1'b0) begin n_err++; $display("FAIL areset_read: got %b want 0", cnt_read); end
        @(negedge clk);
        reset_b = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL areset_idle: got %0d want 0", state); end
        n_cmp++; if (cnt_enable !== 1'b0) begin n_err++; $display("FAIL areset_no_tick: got %b want 0", cnt_enable); end
    endtask

    initial begin
        test_reset();
        test_run();
        test_pause_resume();
        test_clear_priority();
        test_lap();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
